tron_player_motion: RTL and testbench

- Upstream stage of the per-player collision/trail block. Generates one player's grid position (x, y) from direction keys at a fixed game-tick rate.
- Also handles wall collisions and freezes the player when the downstream block reports death.
- One instance per player; its x/y outputs feed the collision stage's coordinate inputs directly.

---
 rtl/tron_pkg.sv | 23 ++
 rtl/tron_player_motion_if.sv | 23 ++
 rtl/tron_tick_gen.sv | 28 ++
 rtl/tron_player_motion.sv | 122 ++++++++++++
 tb/tb_tron_player_motion.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/tron_pkg.sv
// Shared encodings and helpers for the tron player motion block.
package tron_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_STOPPED = 2'd2;

  localparam int GRID_W_DEF = 160;
  localparam int GRID_H_DEF = 120;

  // Opposite headings share the axis bit and differ in the sign bit.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/tron_player_motion_if.sv
// Control/status bundle between a player motion block and its consumer.
interface tron_player_motion_if;
  logic       start;
  logic       pause;
  logic [3:0] key_n;
  logic       dead;
  logic [9:0] x;
  logic [9:0] y;
  logic [1:0] dir;
  logic       step_valid;
  logic       wall_hit;
  logic       running;

  modport master (
    output start, pause, key_n, dead,
    input  x, y, dir, step_valid, wall_hit, running
  );

  modport slave (
    input  start, pause, key_n, dead,
    output x, y, dir, step_valid, wall_hit, running
  );
endinterface

// File: rtl/tron_tick_gen.sv
// Game-tick generator: counts enabled cycles and pulses tick on the wrap cycle.
module tron_tick_gen #(
  parameter int TICK_DIV = 2500000
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) cnt_d = '0;
    else if (en)     cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/tron_player_motion.sv
// One player's grid position, stepped from the direction keys on each game tick.
//   state      | meaning
//   ST_IDLE    | waiting for start, tick counter held at 0
//   ST_RUN     | counting ticks and stepping the player
//   ST_STOPPED | wall hit or death; frozen until reset
module tron_player_motion
  import tron_pkg::*;
#(
  parameter int   TICK_DIV  = 2500000,
  parameter int   GRID_W    = GRID_W_DEF,
  parameter int   GRID_H    = GRID_H_DEF,
  parameter int   START_X   = 40,
  parameter int   START_Y   = 60,
  parameter dir_t START_DIR = DIR_RIGHT
) (
  input logic clk,
  input logic resetn,
  tron_player_motion_if.slave bus
);
  localparam logic [9:0] X_MAX = 10'(GRID_W - 1);
  localparam logic [9:0] Y_MAX = 10'(GRID_H - 1);

  logic [3:0] key_s1_q, key_s2_q, req;
  logic [1:0] state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d, nx, ny;
  dir_t       dir_q, dir_d, pending_q, pending_d, req_dir, head;
  logic       step_q, step_d, wall_q, wall_d;
  logic       tick, blocked;

  tron_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .en     ((state_q == ST_RUN) && !bus.pause),
    .clr    (state_q == ST_IDLE),
    .tick   (tick)
  );

  assign req = ~key_s2_q;

  always_comb begin
    req_dir = DIR_RIGHT;
    if (req[3])      req_dir = DIR_UP;
    else if (req[2]) req_dir = DIR_DOWN;
    else if (req[1]) req_dir = DIR_LEFT;
    pending_d = pending_q;
    if ((|req) && !is_reverse(req_dir, dir_q)) pending_d = req_dir;
  end

  // Pending was filtered against an older dir; re-check against the committed one.
  assign head = is_reverse(pending_q, dir_q) ? dir_q : pending_q;

  always_comb begin
    nx      = x_q;
    ny      = y_q;
    blocked = 1'b0;
    case (head)
      DIR_UP:    if (y_q == 10'd0)  blocked = 1'b1; else ny = y_q - 10'd1;
      DIR_DOWN:  if (y_q >= Y_MAX)  blocked = 1'b1; else ny = y_q + 10'd1;
      DIR_LEFT:  if (x_q == 10'd0)  blocked = 1'b1; else nx = x_q - 10'd1;
      default:   if (x_q >= X_MAX)  blocked = 1'b1; else nx = x_q + 10'd1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    wall_d  = wall_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.dead) begin
          state_d = ST_STOPPED;
        end else if (tick) begin
          if (blocked) begin
            wall_d  = 1'b1;
            state_d = ST_STOPPED;
          end else begin
            x_d    = nx;
            y_d    = ny;
            dir_d  = head;
            step_d = 1'b1;
          end
        end
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      key_s1_q  <= 4'hF;
      key_s2_q  <= 4'hF;
      state_q   <= ST_IDLE;
      x_q       <= 10'(START_X);
      y_q       <= 10'(START_Y);
      dir_q     <= START_DIR;
      pending_q <= START_DIR;
      step_q    <= 1'b0;
      wall_q    <= 1'b0;
    end else begin
      key_s1_q  <= bus.key_n;
      key_s2_q  <= key_s1_q;
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      step_q    <= step_d;
      wall_q    <= wall_d;
    end
  end

  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.dir        = dir_q;
  assign bus.step_valid = step_q;
  assign bus.wall_hit   = wall_q;
  assign bus.running    = (state_q == ST_RUN);
endmodule

// File: tb/tb_tron_player_motion.sv
// Directed bench for tron_player_motion with TICK_DIV=8; second instance starts near the right wall.
module tb_tron_player_motion;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  tron_player_motion_if bus ();
  tron_player_motion_if bus2 ();

  tron_player_motion #(.TICK_DIV(8)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );
  tron_player_motion #(.TICK_DIV(8), .START_X(158)) dut2 (
    .clk(clk), .resetn(resetn), .bus(bus2)
  );

  always #5 clk = ~clk;

  task automatic wait_step(input int budget, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.step_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.start = 0; bus.pause = 0; bus.key_n = 4'hF; bus.dead = 0;
    bus2.start = 0; bus2.pause = 0; bus2.key_n = 4'hF; bus2.dead = 0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.x !== 10'd40) begin miscompares++; $display("FAIL reset_x got %0d want 40", bus.x); end
    vectors++; if (bus.y !== 10'd60) begin miscompares++; $display("FAIL reset_y got %0d want 60", bus.y); end
    vectors++; if (bus.dir !== 2'd3) begin miscompares++; $display("FAIL reset_dir got %0d want 3", bus.dir); end
    vectors++; if ({bus.step_valid, bus.wall_hit, bus.running} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags got %b want 000", {bus.step_valid, bus.wall_hit, bus.running}); end
    vectors++; if (bus2.x !== 10'd158) begin miscompares++; $display("FAIL reset_x2 got %0d want 158", bus2.x); end
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    vectors++; if (bus.running !== 1'b0) begin miscompares++; $display("FAIL idle_running got %b want 0", bus.running); end
  endtask

  task automatic test_straight();
    int n; bit ok;
    bus.start = 1'b1;
    wait_step(20, n, ok);
    vectors++; if (!ok || n != 9) begin miscompares++; $display("FAIL first_step_latency got %0d ok=%0d want 9", n, ok); end
    vectors++; if (bus.x !== 10'd41) begin miscompares++; $display("FAIL first_step_x got %0d want 41", bus.x); end
    for (int i = 0; i < 2; i++) begin
      wait_step(20, n, ok);
      vectors++; if (!ok || n != 8) begin miscompares++; $display("FAIL step_period got %0d ok=%0d want 8", n, ok); end
      vectors++; if (bus.x !== 10'(42 + i) || bus.y !== 10'd60 || bus.dir !== 2'd3) begin
        miscompares++; $display("FAIL straight_pos got x=%0d y=%0d dir=%0d want x=%0d y=60 dir=3", bus.x, bus.y, bus.dir, 42 + i); end
    end
  endtask

  task automatic test_reverse();
    int n; bit ok;
    bus.key_n = 4'b1101;
    wait_step(20, n, ok);
    bus.key_n = 4'hF;
    vectors++; if (!ok || bus.x !== 10'd44 || bus.dir !== 2'd3) begin
      miscompares++; $display("FAIL reverse_ignored got x=%0d dir=%0d ok=%0d want x=44 dir=3", bus.x, bus.dir, ok); end
    bus.key_n = 4'b0111;
    repeat (3) @(negedge clk);
    bus.key_n = 4'hF;
    wait_step(20, n, ok);
    vectors++; if (!ok || bus.y !== 10'd59 || bus.x !== 10'd44 || bus.dir !== 2'd0) begin
      miscompares++; $display("FAIL turn_up got x=%0d y=%0d dir=%0d want x=44 y=59 dir=0", bus.x, bus.y, bus.dir); end
  endtask

  task automatic test_last_key_wins();
    int n; bit ok;
    bus.key_n = 4'b1101;
    repeat (3) @(negedge clk);
    bus.key_n = 4'hF;
    wait_step(20, n, ok);
    vectors++; if (!ok || bus.x !== 10'd43 || bus.y !== 10'd59 || bus.dir !== 2'd2) begin
      miscompares++; $display("FAIL turn_left got x=%0d y=%0d dir=%0d want x=43 y=59 dir=2", bus.x, bus.y, bus.dir); end
    bus.key_n = 4'b1011;
    repeat (2) @(negedge clk);
    bus.key_n = 4'b0111;
    repeat (2) @(negedge clk);
    bus.key_n = 4'hF;
    wait_step(20, n, ok);
    vectors++; if (!ok || bus.x !== 10'd43 || bus.y !== 10'd58 || bus.dir !== 2'd0) begin
      miscompares++; $display("FAIL down_then_up got x=%0d y=%0d dir=%0d want x=43 y=58 dir=0", bus.x, bus.y, bus.dir); end
  endtask

  task automatic test_wall();
    int n; int steps; bit ok;
    bus.pause = 1'b1;
    bus2.start = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk); n++;
      if (bus2.step_valid) ok = 1'b1;
    end
    vectors++; if (!ok || n != 9 || bus2.x !== 10'd159 || bus2.wall_hit !== 1'b0) begin
      miscompares++; $display("FAIL edge_step got x=%0d n=%0d wall=%b want x=159 n=9 wall=0", bus2.x, n, bus2.wall_hit); end
    steps = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus2.step_valid) steps++;
      if (i == 7) begin
        vectors++; if (bus2.wall_hit !== 1'b0) begin miscompares++; $display("FAIL wall_early got %b want 0", bus2.wall_hit); end
      end
    end
    vectors++; if (bus2.wall_hit !== 1'b1 || bus2.running !== 1'b0 || bus2.x !== 10'd159 || steps != 0) begin
      miscompares++; $display("FAIL wall_stop got wall=%b run=%b x=%0d steps=%0d want 1 0 159 0", bus2.wall_hit, bus2.running, bus2.x, steps); end
    repeat (40) begin
      @(negedge clk);
      if (bus2.step_valid) steps++;
    end
    vectors++; if (steps != 0 || bus2.x !== 10'd159 || bus2.wall_hit !== 1'b1) begin
      miscompares++; $display("FAIL wall_frozen got steps=%0d x=%0d wall=%b want 0 159 1", steps, bus2.x, bus2.wall_hit); end
  endtask

  task automatic test_pause();
    int n; bit ok;
    bus.pause = 1'b0;
    wait_step(20, n, ok);
    vectors++; if (!ok || n != 8 || bus.y !== 10'd57) begin
      miscompares++; $display("FAIL resume_step got n=%0d y=%0d want n=8 y=57", n, bus.y); end
    bus.pause = 1'b1;
    repeat (20) @(negedge clk);
    vectors++; if (bus.y !== 10'd57) begin miscompares++; $display("FAIL paused_hold got y=%0d want 57", bus.y); end
    bus.pause = 1'b0;
    wait_step(20, n, ok);
    vectors++; if (!ok || n != 8 || bus.y !== 10'd56 || bus.x !== 10'd43) begin
      miscompares++; $display("FAIL pause_delay got n=%0d x=%0d y=%0d want n=8 x=43 y=56", n, bus.x, bus.y); end
  endtask

  task automatic test_dead_on_tick();
    int steps;
    repeat (7) @(negedge clk);
    bus.dead = 1'b1;
    @(negedge clk);
    vectors++; if (bus.step_valid !== 1'b0 || bus.y !== 10'd56 || bus.running !== 1'b0 || bus.wall_hit !== 1'b0) begin
      miscompares++; $display("FAIL dead_on_tick got sv=%b y=%0d run=%b wall=%b want 0 56 0 0", bus.step_valid, bus.y, bus.running, bus.wall_hit); end
    bus.dead = 1'b0;
    steps = 0;
    repeat (16) begin
      @(negedge clk);
      if (bus.step_valid) steps++;
    end
    vectors++; if (steps != 0 || bus.y !== 10'd56 || bus.x !== 10'd43) begin
      miscompares++; $display("FAIL stopped_hold got steps=%0d x=%0d y=%0d want 0 43 56", steps, bus.x, bus.y); end
  endtask

  task automatic test_back_to_back();
    int n; int steps; bit ok;
    bus.start = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    wait_step(20, n, ok);
    vectors++; if (!ok || n != 9 || bus.x !== 10'd41) begin
      miscompares++; $display("FAIL restart_step got n=%0d x=%0d want n=9 x=41", n, bus.x); end
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    vectors++; if (bus.x !== 10'd40 || bus.y !== 10'd60 || bus.dir !== 2'd3 || bus.running !== 1'b0 || bus.step_valid !== 1'b0) begin
      miscompares++; $display("FAIL midrun_reset got x=%0d y=%0d dir=%0d run=%b sv=%b want 40 60 3 0 0",
                              bus.x, bus.y, bus.dir, bus.running, bus.step_valid); end
    steps = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.step_valid) steps++;
    end
    vectors++; if (steps != 0 || bus.x !== 10'd40 || bus.running !== 1'b0) begin
      miscompares++; $display("FAIL idle_after_reset got steps=%0d x=%0d run=%b want 0 40 0", steps, bus.x, bus.running); end
    bus.start = 1'b1;
    wait_step(20, n, ok);
    vectors++; if (!ok || n != 9 || bus.x !== 10'd41) begin
      miscompares++; $display("FAIL second_start got n=%0d x=%0d want n=9 x=41", n, bus.x); end
    bus.key_n = 4'b0011;
    repeat (3) @(negedge clk);
    bus.key_n = 4'hF;
    wait_step(20, n, ok);
    vectors++; if (!ok || bus.y !== 10'd59 || bus.x !== 10'd41 || bus.dir !== 2'd0) begin
      miscompares++; $display("FAIL key_priority got x=%0d y=%0d dir=%0d want x=41 y=59 dir=0", bus.x, bus.y, bus.dir); end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_reverse();
    test_last_key_wins();
    test_wall();
    test_pause();
    test_dead_on_tick();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
